// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit
// Purpose  : Write-back end of an 8 x 16-bit register file. Completed results
//            (ALU, load, or 32-bit MUL split into low/high halves) are queued
//            in a small FIFO. One entry per cycle is driven onto the register
//            file write port pair. A per-register pending-write scoreboard
//            lets decode stall on hazards.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH  FIFO entries (power of two, 2..16)
//   CNT_W  width of each per-register pending counter
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset, clears all state
//   i_in_valid/o_in_ready  result handshake (o_in_ready = FIFO not full)
//   i_in_wr_low/high       half-write enables of the offered result
//   i_in_dst_low/high      destination registers of the two halves
//   i_in_data_low/high     data of the two halves
//   i_alloc_valid          decode reserves destination(s)
//   o_alloc_ready          0 when a targeted counter is saturated
//   i_alloc_wr_low/high    which destinations to reserve
//   i_alloc_dst_low/high   destination registers to reserve
//   o_reg_write_low/high   register file write strobes (one cycle per entry)
//   o_reg_dst_low/high     register file write addresses
//   o_data_low/high        register file write data
//   o_busy                 busy[r] = register r has pending writes
// Configuration
//   WB_BYPASS_EN  when defined, a result arriving at an empty FIFO is loaded
//                 straight into the output stage (latency 1 instead of 2).
// ============================================================================
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_wr_low,
  input  logic        i_in_wr_high,
  input  logic [2:0]  i_in_dst_low,
  input  logic [2:0]  i_in_dst_high,
  input  logic [15:0] i_in_data_low,
  input  logic [15:0] i_in_data_high,
  input  logic        i_alloc_valid,
  output logic        o_alloc_ready,
  input  logic        i_alloc_wr_low,
  input  logic        i_alloc_wr_high,
  input  logic [2:0]  i_alloc_dst_low,
  input  logic [2:0]  i_alloc_dst_high,
  output logic        o_reg_write_low,
  output logic        o_reg_write_high,
  output logic [2:0]  o_reg_dst_low,
  output logic [2:0]  o_reg_dst_high,
  output logic [15:0] o_data_low,
  output logic [15:0] o_data_high,
  output logic [7:0]  o_busy
);

  localparam int           c_AW    = $clog2(DEPTH);
  localparam int           c_EW    = 40;  // {wl, wh, dl[2:0], dh[2:0], xl[15:0], xh[15:0]}
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Input normalisation: a double write to one register keeps only the low half
  // --------------------------------------------------------------------------
  logic w_in_wh;
  logic w_in_any;
  logic w_in_hs;
  logic [c_EW-1:0] w_in_entry;

  assign w_in_wh    = i_in_wr_high & ~(i_in_wr_low & (i_in_dst_low == i_in_dst_high));
  assign w_in_any   = i_in_wr_low | w_in_wh;
  assign w_in_hs    = i_in_valid & o_in_ready;
  assign w_in_entry = {i_in_wr_low, w_in_wh, i_in_dst_low, i_in_dst_high,
                       i_in_data_low, i_in_data_high};

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_count == '0);
  assign o_in_ready = (r_count != c_FULL);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_in_hs & w_in_any & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // Entries with no write enable are accepted but never stored.
  assign w_push = w_in_hs & w_in_any & ~w_bypass;
  assign w_pop  = ~w_empty;

  // Storage needs no reset: r_count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: loads the FIFO head, or the incoming entry on bypass
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] w_ld_entry;
  logic            w_ld;
  logic            w_ld_wl;
  logic            w_ld_wh;
  logic [2:0]      w_ld_dl;
  logic [2:0]      w_ld_dh;
  logic [15:0]     w_ld_xl;
  logic [15:0]     w_ld_xh;

  assign w_ld_entry = w_pop ? r_mem[r_rd_ptr] : w_in_entry;
  assign w_ld       = w_pop | w_bypass;
  assign w_ld_wl    = w_ld & w_ld_entry[39];
  assign w_ld_wh    = w_ld & w_ld_entry[38];
  assign w_ld_dl    = w_ld_entry[37:35];
  assign w_ld_dh    = w_ld_entry[34:32];
  assign w_ld_xl    = w_ld_entry[31:16];
  assign w_ld_xh    = w_ld_entry[15:0];

  logic        r_wl;
  logic        r_wh;
  logic [2:0]  r_dl;
  logic [2:0]  r_dh;
  logic [15:0] r_xl;
  logic [15:0] r_xh;

  // Each half's address/data only changes when that half is written,
  // so an unwritten half keeps showing its previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wl <= 1'b0;
      r_wh <= 1'b0;
      r_dl <= '0;
      r_dh <= '0;
      r_xl <= '0;
      r_xh <= '0;
    end else begin
      r_wl <= w_ld_wl;
      r_wh <= w_ld_wh;
      if (w_ld_wl) begin
        r_dl <= w_ld_dl;
        r_xl <= w_ld_xl;
      end
      if (w_ld_wh) begin
        r_dh <= w_ld_dh;
        r_xh <= w_ld_xh;
      end
    end
  end

  assign o_reg_write_low  = r_wl;
  assign o_reg_write_high = r_wh;
  assign o_reg_dst_low    = r_dl;
  assign o_reg_dst_high   = r_dh;
  assign o_data_low       = r_xl;
  assign o_data_high      = r_xh;

  // --------------------------------------------------------------------------
  // Pending-write scoreboard
  // --------------------------------------------------------------------------
  logic       w_al_wh;
  logic       w_al_hs;
  logic [7:0] w_at_max;

  assign w_al_wh = i_alloc_wr_high & ~(i_alloc_wr_low & (i_alloc_dst_low == i_alloc_dst_high));

  assign o_alloc_ready = ~((i_alloc_wr_low & w_at_max[i_alloc_dst_low]) |
                           (w_al_wh        & w_at_max[i_alloc_dst_high]));
  assign w_al_hs = i_alloc_valid & o_alloc_ready;

  generate
    for (genvar g = 0; g < 8; g++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      // Increment cannot overflow: the handshake is refused at saturation.
      assign w_inc = w_al_hs & ((i_alloc_wr_low & (i_alloc_dst_low  == 3'(g))) |
                                (w_al_wh        & (i_alloc_dst_high == 3'(g))));
      // Retire happens on the edge that loads the write strobe; ignored at 0.
      assign w_dec = ((w_ld_wl & (w_ld_dl == 3'(g))) |
                      (w_ld_wh & (w_ld_dh == 3'(g)))) & (r_cnt != '0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_inc & ~w_dec) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (~w_inc & w_dec) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_at_max[g] = &r_cnt;
      assign o_busy[g]   = |r_cnt;
    end
  endgenerate

endmodule
`default_nettype wire
